// File: rtl/config_int_add_inmux_lvl_pipe_if.sv
// Operand/result stream and configuration handshake bundle for config_int_add_inmux_lvl_pipe.
// master = producer/consumer side, slave = the adder.
interface config_int_add_inmux_lvl_pipe_if #(
  parameter int BWOP = 32,
  parameter int NABW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [BWOP-1:0] a;
  logic [BWOP-1:0] b;
  logic            cfg_load;
  logic            apx_ctl;
  logic [NABW-1:0] apx_nab;
  logic            cfg_ack;
  logic            out_valid;
  logic            out_ready;
  logic [BWOP-1:0] c;
  logic            c_cout;

  modport master (
    output in_valid, a, b, cfg_load, apx_ctl, apx_nab, out_ready,
    input  in_ready, cfg_ack, out_valid, c, c_cout
  );

  modport slave (
    input  in_valid, a, b, cfg_load, apx_ctl, apx_nab, out_ready,
    output in_ready, cfg_ack, out_valid, c, c_cout
  );
endinterface

// File: rtl/config_int_add_inmux_lvl_pipe.sv
// Runtime-configurable truncating adder, 2-stage valid/ready pipeline with drain-before-reconfigure.
// Optional build macro APX_RND_EN adds carry-in compensation at the truncation boundary.
module config_int_add_inmux_lvl_pipe #(
  parameter int BWOP    = 32,
  parameter int NAB_MAX = 8,
  parameter int NABW    = 4
) (
  input  logic clk,
  input  logic rst,
  config_int_add_inmux_lvl_pipe_if.slave io
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          state_r;
  logic            cfg_ctl_r;
  logic [NABW-1:0] cfg_nab_r;
  logic            pend_ctl_r;
  logic [NABW-1:0] pend_nab_r;
  logic            cfg_ack_r;

  logic            s1_v_r;
  logic [BWOP-1:0] s1_a_r;
  logic [BWOP-1:0] s1_b_r;
  logic            s2_v_r;
  logic [BWOP:0]   s2_sum_r;

  logic [NABW-1:0] nab_act_s;
  logic [BWOP-1:0] mask_s;
  logic            s2_adv_s;
  logic            s1_adv_s;
  logic            in_ready_s;
  logic            in_xfer_s;
  logic            pend_ctl_nxt_s;
  logic [NABW-1:0] pend_nab_nxt_s;
  logic [BWOP:0]   sum_s;

`ifdef APX_RND_EN
  logic [BWOP-1:0] ab_sh_s;
  logic            cin_s;
  logic            s1_cin_r;
`endif

  // Active truncation width: zero in exact mode, clamped to NAB_MAX otherwise
  always_comb begin
    if (!cfg_ctl_r) begin
      nab_act_s = {NABW{1'b0}};
    end else if (cfg_nab_r > NABW'(NAB_MAX)) begin
      nab_act_s = NABW'(NAB_MAX);
    end else begin
      nab_act_s = cfg_nab_r;
    end
    mask_s = {BWOP{1'b1}} << nab_act_s;
  end

`ifdef APX_RND_EN
  // Compensation carry comes from the highest dropped bit of both raw operands
  always_comb begin
    if (nab_act_s != {NABW{1'b0}}) begin
      ab_sh_s = (io.a & io.b) >> (nab_act_s - NABW'(1));
      cin_s   = ab_sh_s[0];
    end else begin
      ab_sh_s = {BWOP{1'b0}};
      cin_s   = 1'b0;
    end
  end
`endif

  // Stage-advance and input-acceptance conditions
  always_comb begin
    s2_adv_s   = ~s2_v_r | io.out_ready;
    s1_adv_s   = s2_adv_s | ~s1_v_r;
    in_ready_s = (state_r == ST_RUN) & s1_adv_s;
    in_xfer_s  = io.in_valid & in_ready_s;
  end

  // Last cfg_load in a drain episode wins, including one coinciding with the exit cycle
  always_comb begin
    if (io.cfg_load) begin
      pend_ctl_nxt_s = io.apx_ctl;
      pend_nab_nxt_s = io.apx_nab;
    end else begin
      pend_ctl_nxt_s = pend_ctl_r;
      pend_nab_nxt_s = pend_nab_r;
    end
  end

  // Stage-2 adder; the config is stable while data is in flight, so nab_act_s is valid here
  always_comb begin
`ifdef APX_RND_EN
    sum_s = {1'b0, s1_a_r} + {1'b0, s1_b_r} + ({{BWOP{1'b0}}, s1_cin_r} << nab_act_s);
`else
    sum_s = {1'b0, s1_a_r} + {1'b0, s1_b_r};
`endif
  end

  // Config FSM: RUN accepts data; DRAIN blocks input until both stages are empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      cfg_ctl_r  <= 1'b0;
      cfg_nab_r  <= {NABW{1'b0}};
      pend_ctl_r <= 1'b0;
      pend_nab_r <= {NABW{1'b0}};
      cfg_ack_r  <= 1'b0;
    end else begin
      pend_ctl_r <= pend_ctl_nxt_s;
      pend_nab_r <= pend_nab_nxt_s;
      cfg_ack_r  <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (io.cfg_load) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!s1_v_r && !s2_v_r) begin
            cfg_ctl_r <= pend_ctl_nxt_s;
            cfg_nab_r <= pend_nab_nxt_s;
            cfg_ack_r <= 1'b1;
            state_r   <= ST_RUN;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Stage 1: masked operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r <= 1'b0;
      s1_a_r <= {BWOP{1'b0}};
      s1_b_r <= {BWOP{1'b0}};
`ifdef APX_RND_EN
      s1_cin_r <= 1'b0;
`endif
    end else if (s1_adv_s) begin
      s1_v_r <= in_xfer_s;
      if (in_xfer_s) begin
        s1_a_r <= io.a & mask_s;
        s1_b_r <= io.b & mask_s;
`ifdef APX_RND_EN
        s1_cin_r <= cin_s;
`endif
      end
    end
  end

  // Stage 2: registered sum; held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_r   <= 1'b0;
      s2_sum_r <= {(BWOP+1){1'b0}};
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_sum_r <= sum_s;
      end
    end
  end

  assign io.in_ready  = in_ready_s;
  assign io.cfg_ack   = cfg_ack_r;
  assign io.out_valid = s2_v_r;
  assign io.c         = s2_sum_r[BWOP-1:0];
  assign io.c_cout    = s2_sum_r[BWOP];

endmodule

// File: tb/tb_config_int_add_inmux_lvl_pipe.sv
// Bench for config_int_add_inmux_lvl_pipe: directed table, drain/reset sequences and
// randomized traffic against an arithmetic reference model (honours APX_RND_EN).
module tb_config_int_add_inmux_lvl_pipe;

  logic clk;
  logic rst;

  config_int_add_inmux_lvl_pipe_if #(.BWOP(32), .NABW(4)) io ();

  config_int_add_inmux_lvl_pipe #(.BWOP(32), .NAB_MAX(8), .NABW(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;
  int n_sent;
  int n_recv;
  int n_ack;
  int n_episode;
  int last_in_cyc;
  int last_out_cyc;
  logic [32:0] last_out;
  logic [32:0] exp_q[$];
  logic [32:0] out_log[$];
  logic        m_ctl;
  logic [3:0]  m_nab;
  logic        draining;
  logic        prev_stall;
  logic [32:0] prev_out;

  typedef struct {
    logic        ctl;
    logic [3:0]  nab;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Plain-arithmetic model: drop the low n bits of each operand, add, optional carry at bit n
  function automatic logic [32:0] ref_sum(input logic [31:0] av, input logic [31:0] bv,
                                          input logic ctl, input logic [3:0] nab);
    int n;
    longint unsigned p, am, bm, s;
    n  = ctl ? ((nab > 4'd8) ? 8 : int'(nab)) : 0;
    p  = 64'd1 << n;
    am = (64'(av) / p) * p;
    bm = (64'(bv) / p) * p;
    s  = am + bm;
`ifdef APX_RND_EN
    if (n > 0 && ((64'(av) / (p / 2)) % 2 == 1) && ((64'(bv) / (p / 2)) % 2 == 1))
      s = s + p;
`endif
    return s[32:0];
  endfunction

  // One clock: observe at negedge, update scoreboard/config model, re-align to posedge+1
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      chk("hold_valid", 64'(io.out_valid), 64'd1);
      chk("hold_data", 64'({io.c_cout, io.c}), 64'(prev_out));
    end
    prev_stall = io.out_valid && !io.out_ready;
    prev_out   = {io.c_cout, io.c};
    if (io.cfg_ack) begin
      n_ack++;
      chk("ack_expected", 64'(draining), 64'd1);
      chk("ack_in_ready", 64'(io.in_ready), 64'd1);
      draining = 1'b0;
    end else if (draining) begin
      chk("drain_in_ready", 64'(io.in_ready), 64'd0);
    end
    if (io.in_valid && io.in_ready) begin
      exp_q.push_back(ref_sum(io.a, io.b, m_ctl, m_nab));
      n_sent++;
      last_in_cyc = cyc;
    end
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("output_without_input", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 64'({io.c_cout, io.c}), 64'(e));
      end
      last_out     = {io.c_cout, io.c};
      last_out_cyc = cyc;
      out_log.push_back(last_out);
      n_recv++;
    end
    if (io.cfg_load) begin
      if (!draining) n_episode++;
      draining = 1'b1;
      m_ctl    = io.apx_ctl;
      m_nab    = io.apx_nab;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic ctl, input logic [3:0] nab);
    int a0;
    int k;
    a0 = n_ack;
    io.cfg_load = 1'b1;
    io.apx_ctl  = ctl;
    io.apx_nab  = nab;
    step();
    io.cfg_load = 1'b0;
    k = 0;
    while (draining && k < 30) begin
      step();
      k++;
    end
    chk("cfg_ack_count", 64'(n_ack - a0), 64'd1);
  endtask

  task automatic send_check(input logic [31:0] av, input logic [31:0] bv,
                            input logic [32:0] exp, input string nm);
    int s0;
    int r0;
    int k;
    s0 = n_sent;
    r0 = n_recv;
    io.a = av;
    io.b = bv;
    io.in_valid  = 1'b1;
    io.out_ready = 1'b1;
    k = 0;
    while (n_sent == s0 && k < 20) begin
      step();
      k++;
    end
    io.in_valid = 1'b0;
    k = 0;
    while (n_recv == r0 && k < 20) begin
      step();
      k++;
    end
    chk({nm, "_done"}, 64'(n_recv - r0), 64'd1);
    chk(nm, 64'(last_out), 64'(exp));
    chk({nm, "_latency"}, 64'(last_out_cyc - last_in_cyc), 64'd2);
  endtask

  initial begin
    int r0;
    int cnt;
    int s0;
    int a0;
    int k;
    n_checks = 0; n_fail = 0; cyc = 0; n_sent = 0; n_recv = 0; n_ack = 0; n_episode = 0;
    last_in_cyc = 0; last_out_cyc = 0; last_out = 33'd0;
    m_ctl = 1'b0; m_nab = 4'd0; draining = 1'b0; prev_stall = 1'b0; prev_out = 33'd0;

    vt[0] = '{1'b0, 4'd0,  32'h0000_001F, 32'h0000_0011, 33'h0_0000_0030, "exact"};
    vt[1] = '{1'b1, 4'd4,  32'h0000_001F, 32'h0000_0011, 33'h0_0000_0020, "apx4"};
`ifdef APX_RND_EN
    vt[2] = '{1'b1, 4'd4,  32'h0000_0018, 32'h0000_0008, 33'h0_0000_0020, "apx4_rnd"};
    vt[3] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FF00, "clamp_carry"};
    vt[7] = '{1'b1, 4'd8,  32'h0000_01FF, 32'h0000_0180, 33'h0_0000_0300, "nab_max"};
    vt[8] = '{1'b1, 4'd9,  32'h0000_01FF, 32'h0000_0180, 33'h0_0000_0300, "nab_over"};
`else
    vt[2] = '{1'b1, 4'd4,  32'h0000_0018, 32'h0000_0008, 33'h0_0000_0010, "apx4_rnd"};
    vt[3] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FE00, "clamp_carry"};
    vt[7] = '{1'b1, 4'd8,  32'h0000_01FF, 32'h0000_0180, 33'h0_0000_0200, "nab_max"};
    vt[8] = '{1'b1, 4'd9,  32'h0000_01FF, 32'h0000_0180, 33'h0_0000_0200, "nab_over"};
`endif
    vt[4] = '{1'b0, 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, "exact_wrap"};
    vt[5] = '{1'b0, 4'd7,  32'h0000_001F, 32'h0000_0011, 33'h0_0000_0030, "ctl0_ignores_nab"};
    vt[6] = '{1'b1, 4'd0,  32'h0000_001F, 32'h0000_0011, 33'h0_0000_0030, "apx_n0"};

    io.in_valid = 1'b0; io.a = 32'd0; io.b = 32'd0; io.cfg_load = 1'b0;
    io.apx_ctl = 1'b0; io.apx_nab = 4'd0; io.out_ready = 1'b0;
    rst = 1'b1;
    #23 rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_cfg_ack", 64'(io.cfg_ack), 64'd0);
    chk("rst_c", 64'(io.c), 64'd0);
    chk("rst_c_cout", 64'(io.c_cout), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      load_cfg(vt[i].ctl, vt[i].nab);
      send_check(vt[i].a, vt[i].b, vt[i].exp, vt[i].nm);
    end

    // Config drain: C rides with cfg_load on old cfg, a second load during DRAIN wins
    load_cfg(1'b0, 4'd0);
    out_log.delete();
    a0 = n_ack;
    io.out_ready = 1'b1;
    io.in_valid = 1'b1; io.a = 32'h5;   io.b = 32'h6;   step();
    io.in_valid = 1'b1; io.a = 32'h100; io.b = 32'h200; step();
    io.in_valid = 1'b1; io.a = 32'h1F;  io.b = 32'h11;
    io.cfg_load = 1'b1; io.apx_ctl = 1'b1; io.apx_nab = 4'd4;
    step();
    io.cfg_load = 1'b0;
    io.out_ready = 1'b0;
    io.a = 32'h1F; io.b = 32'h11;
    step();
    io.cfg_load = 1'b1; io.apx_ctl = 1'b1; io.apx_nab = 4'd2;
    step();
    io.cfg_load = 1'b0;
    step(); step();
    io.out_ready = 1'b1;
    s0 = n_sent;
    k = 0;
    while (n_sent == s0 && k < 30) begin step(); k++; end
    io.in_valid = 1'b0;
    k = 0;
    while (out_log.size() < 4 && k < 30) begin step(); k++; end
    chk("drain_ack_once", 64'(n_ack - a0), 64'd1);
    chk("drain_out_count", 64'(out_log.size()), 64'd4);
    if (out_log.size() == 4) begin
      chk("drain_item_a", 64'(out_log[0]), 64'h0000_000B);
      chk("drain_item_b", 64'(out_log[1]), 64'h0000_0300);
      chk("drain_item_c_oldcfg", 64'(out_log[2]), 64'h0000_0030);
      chk("drain_item_d_lastcfg", 64'(out_log[3]), 64'h0000_002C);
    end

    // Backpressure: 10 random pairs, random out_ready
    load_cfg(1'b1, 4'd3);
    r0 = n_recv; cnt = 0; io.in_valid = 1'b0;
    for (int t = 0; t < 400 && (n_recv - r0) < 10; t++) begin
      if (!io.in_valid && cnt < 10) begin
        io.in_valid = 1'b1;
        io.a = $urandom;
        io.b = $urandom;
      end
      io.out_ready = 1'($urandom_range(0, 1));
      s0 = n_sent;
      step();
      if (n_sent != s0) begin
        cnt++;
        io.in_valid = 1'b0;
      end
    end
    chk("bp_received", 64'(n_recv - r0), 64'd10);

    // Mixed random traffic with random reconfiguration
    for (int t = 0; t < 300; t++) begin
      io.in_valid  = 1'($urandom_range(0, 1));
      io.a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      io.b         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      io.out_ready = 1'($urandom_range(0, 1));
      io.cfg_load  = ($urandom_range(0, 15) == 0);
      io.apx_ctl   = 1'($urandom_range(0, 1));
      io.apx_nab   = 4'($urandom_range(0, 15));
      step();
    end
    io.cfg_load = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b1;
    for (int t = 0; t < 40 && (exp_q.size() != 0 || draining); t++) step();
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("ack_per_episode", 64'(n_ack), 64'(n_episode));

    // Reset mid-stream with an approximate config active
    load_cfg(1'b1, 4'd4);
    io.out_ready = 1'b0;
    s0 = n_sent;
    io.in_valid = 1'b1; io.a = 32'h1F; io.b = 32'h11;
    k = 0;
    while ((n_sent - s0) < 2 && k < 20) begin step(); k++; end
    io.in_valid = 1'b0;
    chk("pre_rst_inflight", 64'(n_sent - s0), 64'd2);
    rst = 1'b1;
    #2;
    chk("mid_rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("mid_rst_c", 64'({io.c_cout, io.c}), 64'd0);
    chk("mid_rst_in_ready", 64'(io.in_ready), 64'd1);
    chk("mid_rst_cfg_ack", 64'(io.cfg_ack), 64'd0);
    #1 rst = 1'b0;
    exp_q.delete();
    m_ctl = 1'b0; m_nab = 4'd0; draining = 1'b0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    send_check(32'h1F, 32'h11, 33'h0_0000_0030, "post_rst_exact");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
